// File: rtl/tx_char_sched.sv
// Transmit character scheduler for the DS link: picks time-code, FCT, N-char or NULL
// at each character boundary, tracks flow-control credit and keeps ESC pairs atomic.
module tx_char_sched (
  input  logic       txClk,
  input  logic       txReset,
  input  logic       sendNulls,
  input  logic       sendFcts,
  input  logic       sendNchars,
  input  logic       fctReq,
  input  logic       rxFct,
  input  logic       tickIn,
  input  logic [7:0] timeIn,
  input  logic       dataValid,
  input  logic [8:0] dataIn,
  output logic       dataPop,
  output logic       charValid,
  output logic       charIsL,
  output logic [7:0] charCode,
  input  logic       charReady,
  output logic [5:0] credit,
  output logic       creditError
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SINGLE = 3'd1;
  localparam logic [2:0] ST_T_ESC  = 3'd2;
  localparam logic [2:0] ST_T_DATA = 3'd3;
  localparam logic [2:0] ST_N_ESC  = 3'd4;
  localparam logic [2:0] ST_N_FCT  = 3'd5;

  localparam logic [1:0] LC_FCT = 2'b00;
  localparam logic [1:0] LC_EOP = 2'b01;
  localparam logic [1:0] LC_EEP = 2'b10;
  localparam logic [1:0] LC_ESC = 2'b11;

  localparam logic [6:0] CREDIT_MAX = 7'd56;

  logic [2:0] state_r;
  logic [2:0] fctPending_r;
  logic       tickPending_r;
  logic [7:0] timeVal_r;

  logic       slotFree_s;
  logic [2:0] nextState_s;
  logic       nextValid_s;
  logic       nextIsL_s;
  logic [7:0] nextCode_s;
  logic       selTick_s;
  logic       selFct_s;
  logic       selN_s;
  logic [6:0] creditSum_s;

  assign slotFree_s  = !charValid || charReady;
  assign dataPop     = selN_s && !txReset;
  assign creditSum_s = {1'b0, credit} + (rxFct ? 7'd8 : 7'd0) - (selN_s ? 7'd1 : 7'd0);

  // Next-character selection: second halves of pairs first, then the priority chain.
  always_comb begin
    nextState_s = state_r;
    nextValid_s = charValid;
    nextIsL_s   = charIsL;
    nextCode_s  = charCode;
    selTick_s   = 1'b0;
    selFct_s    = 1'b0;
    selN_s      = 1'b0;
    if (slotFree_s) begin
      case (state_r)
        ST_T_ESC: begin
          nextState_s = ST_T_DATA;
          nextValid_s = 1'b1;
          nextIsL_s   = 1'b0;
          nextCode_s  = timeVal_r;
        end
        ST_N_ESC: begin
          nextState_s = ST_N_FCT;
          nextValid_s = 1'b1;
          nextIsL_s   = 1'b1;
          nextCode_s  = {6'd0, LC_FCT};
        end
        default: begin
          if (tickPending_r && sendNchars) begin
            selTick_s   = 1'b1;
            nextState_s = ST_T_ESC;
            nextValid_s = 1'b1;
            nextIsL_s   = 1'b1;
            nextCode_s  = {6'd0, LC_ESC};
          end else if ((fctPending_r != 3'd0) && sendFcts) begin
            selFct_s    = 1'b1;
            nextState_s = ST_SINGLE;
            nextValid_s = 1'b1;
            nextIsL_s   = 1'b1;
            nextCode_s  = {6'd0, LC_FCT};
          end else if (dataValid && sendNchars && (credit != 6'd0)) begin
            selN_s      = 1'b1;
            nextState_s = ST_SINGLE;
            nextValid_s = 1'b1;
            if (dataIn[8]) begin
              nextIsL_s  = 1'b1;
              nextCode_s = {6'd0, (dataIn[0] ? LC_EEP : LC_EOP)};
            end else begin
              nextIsL_s  = 1'b0;
              nextCode_s = dataIn[7:0];
            end
          end else if (sendNulls) begin
            nextState_s = ST_N_ESC;
            nextValid_s = 1'b1;
            nextIsL_s   = 1'b1;
            nextCode_s  = {6'd0, LC_ESC};
          end else begin
            nextState_s = ST_IDLE;
            nextValid_s = 1'b0;
            nextIsL_s   = charIsL;
            nextCode_s  = charCode;
          end
        end
      endcase
    end else begin
      nextState_s = state_r;
      nextValid_s = charValid;
    end
  end

  // Output character register and pair-tracking state.
  always_ff @(posedge txClk) begin
    if (txReset) begin
      state_r   <= ST_IDLE;
      charValid <= 1'b0;
      charIsL   <= 1'b0;
      charCode  <= 8'd0;
    end else begin
      state_r   <= nextState_s;
      charValid <= nextValid_s;
      charIsL   <= nextIsL_s;
      charCode  <= nextCode_s;
    end
  end

  // Pending time-code and FCT bookkeeping; a fresh tickIn wins over its own selection.
  always_ff @(posedge txClk) begin
    if (txReset) begin
      tickPending_r <= 1'b0;
      timeVal_r     <= 8'd0;
      fctPending_r  <= 3'd0;
    end else begin
      if (tickIn) begin
        tickPending_r <= 1'b1;
        timeVal_r     <= timeIn;
      end else if (selTick_s) begin
        tickPending_r <= 1'b0;
      end else begin
        tickPending_r <= tickPending_r;
      end
      if (selFct_s && !fctReq) begin
        fctPending_r <= fctPending_r - 3'd1;
      end else if (!selFct_s && fctReq && (fctPending_r != 3'd7)) begin
        fctPending_r <= fctPending_r + 3'd1;
      end else begin
        fctPending_r <= fctPending_r;
      end
    end
  end

  // Credit accounting; an overflowing FCT leaves credit untouched and sets the sticky error.
  always_ff @(posedge txClk) begin
    if (txReset) begin
      credit      <= 6'd0;
      creditError <= 1'b0;
    end else if (rxFct) begin
      if (creditSum_s > CREDIT_MAX) begin
        credit      <= credit;
        creditError <= 1'b1;
      end else begin
        credit      <= creditSum_s[5:0];
        creditError <= creditError;
      end
    end else if (selN_s) begin
      credit      <= credit - 6'd1;
      creditError <= creditError;
    end else begin
      credit      <= credit;
      creditError <= creditError;
    end
  end

endmodule

// File: tb/tb_tx_char_sched.sv
// Scoreboard bench for tx_char_sched: expected characters are queued as stimulus is
// driven and compared as the serializer side accepts them.
module tb_tx_char_sched;

  logic       txClk;
  logic       txReset;
  logic       sendNulls;
  logic       sendFcts;
  logic       sendNchars;
  logic       fctReq;
  logic       rxFct;
  logic       tickIn;
  logic [7:0] timeIn;
  logic       dataValid;
  logic [8:0] dataIn;
  logic       dataPop;
  logic       charValid;
  logic       charIsL;
  logic [7:0] charCode;
  logic       charReady;
  logic [5:0] credit;
  logic       creditError;

  logic [8:0] expQ[$];
  logic [8:0] fifoQ[$];
  int vecCount;
  int missCount;
  int popCount;

  tx_char_sched dut (
    .txClk(txClk), .txReset(txReset), .sendNulls(sendNulls), .sendFcts(sendFcts),
    .sendNchars(sendNchars), .fctReq(fctReq), .rxFct(rxFct), .tickIn(tickIn),
    .timeIn(timeIn), .dataValid(dataValid), .dataIn(dataIn), .dataPop(dataPop),
    .charValid(charValid), .charIsL(charIsL), .charCode(charCode),
    .charReady(charReady), .credit(credit), .creditError(creditError)
  );

  initial txClk = 1'b0;
  always #5 txClk = ~txClk;

  task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecCount = vecCount + 1;
    if (obs !== exp) begin
      missCount = missCount + 1;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic fifoSync();
    if (fifoQ.size() != 0) begin
      dataValid = 1'b1;
      dataIn    = fifoQ[0];
    end else begin
      dataValid = 1'b0;
      dataIn    = 9'd0;
    end
  endtask

  task automatic pushByte(input logic [7:0] b);
    fifoQ.push_back({1'b0, b});
    expQ.push_back({1'b0, b});
    fifoSync();
  endtask

  task automatic expL(input logic [1:0] c);
    expQ.push_back({1'b1, 6'd0, c});
  endtask

  // One clock: entered at posedge+1, samples accepts and pops at negedge, returns at posedge+1.
  task automatic cyc();
    logic popNow;
    logic [8:0] e;
    popNow = 1'b0;
    #4;
    if (charValid && charReady && expQ.size() != 0) begin
      e = expQ.pop_front();
      checkEq("char", 32'({charIsL, charCode}), 32'(e));
    end
    if (dataPop) begin
      checkEq("popValid", 32'(dataValid), 32'd1);
      popCount = popCount + 1;
      popNow = 1'b1;
    end
    @(posedge txClk);
    #1;
    if (popNow && fifoQ.size() != 0) void'(fifoQ.pop_front());
    fifoSync();
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (expQ.size() != 0 && n < budget) begin
      cyc();
      n = n + 1;
    end
    if (expQ.size() != 0) begin
      checkEq("drainTimeout", 32'(expQ.size()), 32'd0);
      expQ.delete();
    end
  endtask

  task automatic doReset();
    txReset = 1'b1;
    sendNulls = 1'b0; sendFcts = 1'b0; sendNchars = 1'b0;
    fctReq = 1'b0; rxFct = 1'b0; tickIn = 1'b0; timeIn = 8'd0; charReady = 1'b0;
    fifoQ.delete();
    expQ.delete();
    fifoSync();
    cyc();
    cyc();
    txReset = 1'b0;
    popCount = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecCount = 0; missCount = 0; popCount = 0;
    txReset = 1'b1;
    @(posedge txClk);
    #1;

    // Reset state, then NULL stream one cycle after release
    doReset();
    checkEq("rstValid", 32'(charValid), 32'd0);
    checkEq("rstIsL", 32'(charIsL), 32'd0);
    checkEq("rstCode", 32'(charCode), 32'd0);
    checkEq("rstPop", 32'(dataPop), 32'd0);
    checkEq("rstCredit", 32'(credit), 32'd0);
    checkEq("rstErr", 32'(creditError), 32'd0);
    sendNulls = 1'b1; charReady = 1'b1;
    for (int i = 0; i < 3; i++) begin expL(2'b11); expL(2'b00); end
    cyc();
    checkEq("nullLatency", 32'(charValid), 32'd1);
    checkEq("nullFirstEsc", 32'({charIsL, charCode}), 32'h103);
    drain(20);

    // Three queued FCTs go out before the first NULL
    doReset();
    fctReq = 1'b1;
    repeat (3) cyc();
    fctReq = 1'b0;
    for (int i = 0; i < 3; i++) expL(2'b00);
    expL(2'b11); expL(2'b00); expL(2'b11); expL(2'b00);
    sendFcts = 1'b1; sendNulls = 1'b1; charReady = 1'b1;
    drain(30);

    // FCT queue saturates at 7
    doReset();
    fctReq = 1'b1;
    repeat (9) cyc();
    fctReq = 1'b0;
    for (int i = 0; i < 7; i++) expL(2'b00);
    expL(2'b11); expL(2'b00); expL(2'b11); expL(2'b00);
    sendFcts = 1'b1; sendNulls = 1'b1; charReady = 1'b1;
    drain(40);

    // Eight credits: 8 N-chars out of 10, then NULLs; then EOP/EEP mapping
    doReset();
    for (int i = 0; i < 10; i++) fifoQ.push_back(9'(i));
    fifoSync();
    for (int i = 0; i < 8; i++) expQ.push_back(9'(i));
    expL(2'b11); expL(2'b00); expL(2'b11); expL(2'b00);
    rxFct = 1'b1;
    cyc();
    rxFct = 1'b0;
    checkEq("credit8", 32'(credit), 32'd8);
    sendNchars = 1'b1; sendNulls = 1'b1; charReady = 1'b1;
    drain(40);
    checkEq("popCount8", 32'(popCount), 32'd8);
    checkEq("credit0", 32'(credit), 32'd0);
    checkEq("fifoLeft", 32'(fifoQ.size()), 32'd2);
    sendNulls = 1'b0;
    repeat (3) cyc();
    expQ.push_back(9'h008); expQ.push_back(9'h009); expL(2'b01); expL(2'b10);
    fifoQ.push_back(9'h100); fifoQ.push_back(9'h101);
    fifoSync();
    rxFct = 1'b1;
    cyc();
    rxFct = 1'b0;
    drain(20);
    checkEq("credit4", 32'(credit), 32'd4);
    checkEq("popCount12", 32'(popCount), 32'd12);

    // Stalled time-code ESC; ticks during the stall set the time byte
    doReset();
    sendNchars = 1'b1; sendFcts = 1'b1;
    tickIn = 1'b1; timeIn = 8'h55;
    cyc();
    tickIn = 1'b0;
    cyc();
    checkEq("tEscPresented", 32'({charValid, charIsL, charCode}), 32'h303);
    fctReq = 1'b1;
    cyc();
    fctReq = 1'b0; tickIn = 1'b1; timeIn = 8'h2A;
    cyc();
    timeIn = 8'h3B;
    cyc();
    tickIn = 1'b0;
    cyc();
    cyc();
    checkEq("tEscHeld", 32'({charValid, charIsL, charCode}), 32'h303);
    expL(2'b11); expQ.push_back(9'h03B); expL(2'b11); expQ.push_back(9'h03B); expL(2'b00);
    charReady = 1'b1;
    drain(20);
    cyc();
    checkEq("idleAfterTick", 32'(charValid), 32'd0);

    // Credit ceiling: coincident rxFct and N-char at 49, then overflow at 56
    doReset();
    rxFct = 1'b1;
    repeat (7) cyc();
    rxFct = 1'b0;
    checkEq("credit56", 32'(credit), 32'd56);
    checkEq("noErr56", 32'(creditError), 32'd0);
    for (int i = 0; i < 7; i++) pushByte(8'hA0 + 8'(i));
    sendNchars = 1'b1; charReady = 1'b1;
    drain(30);
    checkEq("credit49", 32'(credit), 32'd49);
    sendNchars = 1'b0;
    cyc();
    cyc();
    popCount = 0;
    pushByte(8'hB7);
    sendNchars = 1'b1; rxFct = 1'b1;
    cyc();
    sendNchars = 1'b0; rxFct = 1'b0;
    checkEq("coincCredit", 32'(credit), 32'd56);
    checkEq("coincNoErr", 32'(creditError), 32'd0);
    checkEq("coincPop", 32'(popCount), 32'd1);
    drain(10);
    rxFct = 1'b1;
    cyc();
    rxFct = 1'b0;
    checkEq("ovfCredit", 32'(credit), 32'd56);
    checkEq("ovfErr", 32'(creditError), 32'd1);
    repeat (3) cyc();
    checkEq("errSticky", 32'(creditError), 32'd1);
    doReset();
    checkEq("errCleared", 32'(creditError), 32'd0);

    // Reset while the FCT half of a NULL is presented
    sendNulls = 1'b1; charReady = 1'b1;
    cyc();
    checkEq("pairEsc", 32'({charValid, charIsL, charCode}), 32'h303);
    cyc();
    checkEq("pairFct", 32'({charValid, charIsL, charCode}), 32'h300);
    txReset = 1'b1;
    cyc();
    checkEq("midRstChar", 32'({charValid, charIsL, charCode}), 32'h000);
    checkEq("midRstCredit", 32'({creditError, credit}), 32'd0);
    txReset = 1'b0;
    cyc();
    checkEq("freshEsc", 32'({charValid, charIsL, charCode}), 32'h303);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule

// File: doc/tx_char_sched.md
# tx_char_sched

Transmit-side character scheduler for the DS link. Each character boundary it chooses what the DS serializer sends next: time-code, FCT, N-char or NULL. It tracks transmit flow-control credit, queues pending FCTs and keeps two-character sequences (NULL, time-code) atomic. It sits between the link state machine, the transmit FIFO, the receiver's FCT detector and the serializer, and is the transmit counterpart of the receiver's character decoder.

## Interface
- No parameters; credit limit 56 and FCT queue depth 7 are fixed.
- txClk  in  1  sole clock; everything on rising edge
- txReset  in  1  synchronous, active-high reset
- sendNulls  in  1  link SM permits NULLs
- sendFcts  in  1  link SM permits FCTs
- sendNchars  in  1  link SM permits N-chars and time-codes
- fctReq  in  1  one-cycle pulse: queue one FCT for transmission
- rxFct  in  1  one-cycle pulse: FCT received from peer, +8 credit
- tickIn  in  1  one-cycle pulse: time-code request
- timeIn  in  8  time-code value, sampled when tickIn=1
- dataValid  in  1  FWFT transmit FIFO non-empty
- dataIn  in  9  FIFO head: [8]=1 marks end-of-packet, then [0]=0 EOP / [0]=1 EEP; [8]=0 data byte [7:0]
- dataPop  out  1  one-cycle pulse: FIFO head consumed
- charValid  out  1  character presented to serializer
- charIsL  out  1  1 = L-char (code in charCode[1:0]), 0 = N-char (charCode[7:0])
- charCode  out  8  character payload; bits [7:2] = 0 for L-chars
- charReady  in  1  serializer accepts presented char this cycle
- credit  out  6  current transmit credit, 0..56
- creditError  out  1  sticky: rxFct would exceed 56

## Operation
- L-codes: FCT=00, EOP=01, EEP=10, ESC=11. NULL = ESC,FCT. Time-code = ESC, N-char(timeIn).
- Output register: charValid/charIsL/charCode. Slot "free" when charValid=0 or charValid&charReady. Only a free slot may be reloaded. Held char must not change while charValid&!charReady.
- States: IDLE, SINGLE (FCT or N-char/EOP/EEP presented), T_ESC, T_DATA, N_ESC, N_FCT.
- Second half of a pair: T_ESC accepted -> T_DATA (time byte, N-char) next; N_ESC accepted -> N_FCT. Nothing may interleave. Enables are ignored while a second half is pending.
- Selection when slot free and no second half pending, priority high to low:
  1. time-code: tickPending & sendNchars -> T_ESC; clear tickPending.
  2. FCT: fctPending>0 & sendFcts -> SINGLE code 00; fctPending-1.
  3. N-char: dataValid & sendNchars & credit>0 -> SINGLE; map dataIn to data byte / EOP / EEP; dataPop=1 same cycle; credit-1.
  4. NULL: sendNulls -> N_ESC.
  5. Otherwise charValid<=0, IDLE.
- tickPending latches timeIn on tickIn. A new tickIn while pending overwrites value. A tickIn in the cycle the pending tick is selected re-arms pending with the new value.
- fctPending 3-bit, 0..7. Increments on fctReq, saturates at 7 (extra requests dropped). Simultaneous fctReq and selection: unchanged.
- credit 6-bit. rxFct adds 8. If result >56, credit unchanged and creditError<=1. Simultaneous rxFct and N-char selection: net +7, error check on the net result.
- Dropping sendNchars/sendFcts/sendNulls never retracts a presented char. It only affects the next selection.

## Timing
- Reset values: charValid=0, charIsL=0, charCode=0, dataPop=0, credit=0, creditError=0, fctPending=0, tickPending=0, state IDLE.
- Request to charValid: 1 cycle (registered) from IDLE.
- Back-to-back: new char loaded in the same edge that accepts the old one. Sustains 1 char/cycle when charReady stays high.
- dataPop coincides with the edge loading the N-char. Never asserted unless dataValid=1.
- creditError sticky until txReset.
- txReset mid-pair abandons the pair; next char after reset is chosen fresh.

## Test plan
- Reset, sendNulls=1, charReady=1 -> charValid at cycle 1 after reset, stream ESC(11),FCT(00),ESC,FCT... all charIsL=1.
- fctReq x3, sendFcts=1, sendNulls=1 -> three FCT chars before first NULL; fctPending 0 after.
- rxFct once, sendNchars=1, FIFO holds 10 bytes 0x00..0x09 -> exactly 8 N-chars 0x00..0x07 with 8 dataPop pulses, credit 8->0, then NULLs only.
- charReady=0 for 5 cycles after T_ESC presented, tickIn with timeIn=0x2A and 0x3B during stall -> ESC held; then 0x3B time byte (T_DATA) immediately follows the ESC once it is accepted. No FCT/N-char between.
- credit=56, rxFct -> creditError=1, credit stays 56. rxFct coincident with N-char selection at credit=49 -> credit 56, no error.
- Assert txReset while N_FCT pending -> next cycle all outputs at reset values. After release, fresh NULL starts with ESC.
